// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM states, memory-owner encoding, IE source/dest flags
// and the address/data listing helper used to preload RAM images.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cpu_mem_arbiter_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;

    // Arbiter sequencing: grant in IDLE, strobe RAM in ACCESS, return data/ack in RESP.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    // Which stage owns the access currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_IE = 1'b1
    } owner_t;

    // Operand source selector used by the execute stage.
    typedef enum logic [1:0] {
        IE_SRC_REG = 2'd0,
        IE_SRC_IMM = 2'd1,
        IE_SRC_MEM = 2'd2
    } ie_src_t;

    // Result destination selector used by the execute stage.
    typedef enum logic [1:0] {
        IE_DST_NONE = 2'd0,
        IE_DST_REG  = 2'd1,
        IE_DST_MEM  = 2'd2
    } ie_dst_t;

    // One line of a memory listing: 16-bit address, 8-bit byte.
    typedef struct packed {
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] data;
    } listing_entry_t;

    // Listings are written as packed 24-bit words 0xAAAADD (address then byte).
    function automatic listing_entry_t listing_entry(input logic [CPU_ADDR_W+CPU_DATA_W-1:0] word);
        listing_entry_t e;
        e.addr = word[CPU_ADDR_W+CPU_DATA_W-1:CPU_DATA_W];
        e.data = word[CPU_DATA_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF, read-only) and execute (IE, load/store).
// Latency: request seen in IDLE at t -> mem_en at t+1 -> ack + read data at t+2; one access per 3 cycles.
// Backpressure: req/ack handshake; a requester holds req until its one-cycle ack, losers simply wait.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata     fetch read channel
//   ie_req/ie_we/ie_addr/ie_wdata -> ie_ack/ie_rdata   execute load/store channel
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata         synchronous-read RAM port
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int MAX_IE_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              ie_req,
    input  logic              ie_we,
    input  logic [ADDR_W-1:0] ie_addr,
    input  logic [DATA_W-1:0] ie_wdata,
    output logic [DATA_W-1:0] ie_rdata,
    output logic              ie_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = (MAX_IE_STREAK < 1) ? 1 : $clog2(MAX_IE_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_IE_STREAK);

    arb_state_t          r_state;
    owner_t              r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_if_ack;
    logic                r_ie_ack;

    arb_state_t          w_state_nxt;
    owner_t              w_owner_nxt;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_mem_en_nxt;
    logic                w_mem_we_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic                w_if_ack_nxt;
    logic                w_ie_ack_nxt;
    logic                w_ie_wins;

    // IE has priority unless IF is waiting and IE has already used up its streak allowance.
    assign w_ie_wins = ie_req && (!if_req || (r_streak < STREAK_MAX));

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_streak_nxt    = r_streak;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_ie_ack_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ie_wins) begin
                    w_owner_nxt     = OWN_IE;
                    w_mem_addr_nxt  = ie_addr;
                    w_mem_wdata_nxt = ie_wdata;
                    w_mem_we_nxt    = ie_we;
                    w_mem_en_nxt    = 1'b1;
                    w_state_nxt     = ST_ACCESS;
                    // The streak only counts IE grants that actually made IF wait.
                    w_streak_nxt    = if_req ? (r_streak + 1'b1) : '0;
                end else if (if_req) begin
                    w_owner_nxt     = OWN_IF;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_en_nxt    = 1'b1;
                    w_state_nxt     = ST_ACCESS;
                    w_streak_nxt    = '0;
                end
            end
            ST_ACCESS: begin
                // RAM samples at the end of this cycle, so read data lines up with the ack next cycle.
                w_if_ack_nxt = (r_owner == OWN_IF);
                w_ie_ack_nxt = (r_owner == OWN_IE);
                w_state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_ie_ack    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ack    <= w_if_ack_nxt;
            r_ie_ack    <= w_ie_ack_nxt;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign ie_ack    = r_ie_ack;

    // Read data is the RAM output steered to the owner; the other side reads zero.
    assign if_rdata  = r_if_ack ? mem_rdata : '0;
    assign ie_rdata  = r_ie_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by random IF/IE traffic
// checked against a byte-array memory reference and latency/exclusivity rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXS = 4;
    // IF: up to MAXS IE accesses ahead of it plus an access already in flight.
    localparam int IF_MAX_LAT = MAXS * 3 + 2 + 2;
    // IE: at most one forced IF access ahead of it.
    localparam int IE_MAX_LAT = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          ie_req = 1'b0;
    logic          ie_we = 1'b0;
    logic [AW-1:0] ie_addr = '0;
    logic [DW-1:0] ie_wdata = '0;
    logic [DW-1:0] ie_rdata;
    logic          ie_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_IE_STREAK(MAXS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .ie_req   (ie_req),
        .ie_we    (ie_we),
        .ie_addr  (ie_addr),
        .ie_wdata (ie_wdata),
        .ie_rdata (ie_rdata),
        .ie_ack   (ie_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [23:0] listing [0:2] = '{24'h0200A2, 24'h001EAA, 24'h01003C};
    logic [DW-1:0] ram     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int n_cmp  = 0;
    int n_fail = 0;

    // Synchronous-read RAM: data for an access strobed in cycle n appears in cycle n+1.
    initial begin : ram_model
        listing_entry_t e;
        for (int a = 0; a < 65536; a++) ram[a] = '0;
        for (int i = 0; i < 3; i++) begin
            e = listing_entry(listing[i]);
            ram[e.addr] = e.data;
        end
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata = ram[mem_addr];
                if (mem_we) ram[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated access starting in an IDLE cycle; ends on the following IDLE cycle.
    task automatic access_once(input string tag, input logic is_ie, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] exp_rdata);
        if (is_ie) begin
            ie_req = 1'b1; ie_we = we; ie_addr = addr; ie_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        check({tag, "_access"}, 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, is_ie & we, addr}));
        if (is_ie && we) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
        check({tag, "_early_ack"}, 32'({if_ack, ie_ack}), 32'(0));
        tick();
        check({tag, "_ack"}, 32'({if_ack, ie_ack, mem_en, mem_we}), 32'({!is_ie, is_ie, 2'b00}));
        if (!(is_ie && we)) check({tag, "_rdata"}, 32'(is_ie ? ie_rdata : if_rdata), 32'(exp_rdata));
        if (is_ie && we) ref_mem[addr] = wdata;
        if_req = 1'b0; ie_req = 1'b0; ie_we = 1'b0;
        tick();
        check({tag, "_idle"}, 32'({if_ack, ie_ack, mem_en}), 32'(0));
    endtask

    initial begin : main
        listing_entry_t e;
        int ie_before, if_cyc, ie_after_cyc, seen;
        bit if_pend, ie_pend, prev_ack, any_ack, ie_w;
        int if_wait, ie_wait;
        logic [AW-1:0] if_a, ie_a;
        logic [DW-1:0] ie_d;

        for (int a = 0; a < 65536; a++) ref_mem[a] = '0;
        for (int i = 0; i < 3; i++) begin
            e = listing_entry(listing[i]);
            ref_mem[e.addr] = e.data;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_out", 32'({mem_en, mem_we, if_ack, ie_ack, mem_addr, mem_wdata}), 32'(0));
        check("reset_rdata", 32'({if_rdata, ie_rdata}), 32'(0));
        rst = 1'b0;
        tick();

        // Single IF read, then IE store followed by a load of the same byte
        access_once("if_read", 1'b0, 1'b0, 16'h0200, 8'h00, 8'hA2);
        access_once("ie_store", 1'b1, 1'b1, 16'h0005, 8'h0F, 8'h00);
        access_once("ie_load", 1'b1, 1'b0, 16'h0005, 8'h00, 8'h0F);

        // Simultaneous requests: IE first, IF three cycles later
        if_req = 1'b1; if_addr = 16'h0100;
        ie_req = 1'b1; ie_we = 1'b0; ie_addr = 16'h001E;
        tick();
        check("sim_first_addr", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h001E}));
        tick();
        check("sim_ie_ack", 32'({ie_ack, if_ack, ie_rdata}), 32'({2'b10, 8'hAA}));
        ie_req = 1'b0;
        tick();
        tick();
        check("sim_second_addr", 32'({mem_en, mem_addr}), 32'({1'b1, 16'h0100}));
        tick();
        check("sim_if_ack", 32'({ie_ack, if_ack, if_rdata}), 32'({2'b01, ref_mem[16'h0100]}));
        if_req = 1'b0;
        tick();

        // Starvation guard: IE always requesting, IF held until served
        if_req = 1'b1; if_addr = 16'h0200;
        ie_req = 1'b1; ie_we = 1'b0; ie_addr = 16'h001E;
        ie_before = 0; if_cyc = -1; ie_after_cyc = -1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (ie_ack) begin
                if (if_cyc < 0) ie_before++;
                else if (ie_after_cyc < 0) ie_after_cyc = c;
            end
            if (if_ack) begin
                if (if_cyc < 0) if_cyc = c;
                if_req = 1'b0;
            end
        end
        ie_req = 1'b0;
        check("starve_ie_count", 32'(ie_before), 32'(MAXS));
        check("starve_if_cycle", 32'(if_cyc), 32'(MAXS * 3 + 2));
        check("starve_ie_resume", 32'(ie_after_cyc), 32'(MAXS * 3 + 5));
        tick();

        // Reset during ACCESS of the third IE load in a streak
        if_req = 1'b1; if_addr = 16'h0200;
        ie_req = 1'b1; ie_we = 1'b0; ie_addr = 16'h001E;
        seen = 0;
        for (int c = 0; c < 10 && seen < 2; c++) begin
            tick();
            if (ie_ack) seen++;
        end
        check("rst_pre_acks", 32'(seen), 32'(2));
        tick();
        tick();
        check("rst_in_access", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 16'h001E}));
        check("rst_streak_before", 32'(dut.r_streak), 32'(3));
        rst = 1'b1; ie_req = 1'b0;
        tick();
        check("rst_outputs", 32'({mem_en, mem_we, if_ack, ie_ack, mem_addr, mem_wdata}), 32'(0));
        check("rst_rdata", 32'({if_rdata, ie_rdata}), 32'(0));
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("rst_streak", 32'(dut.r_streak), 32'(0));
        rst = 1'b0;
        tick();
        check("rst_if_access", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 16'h0200}));
        tick();
        check("rst_if_ack", 32'({if_ack, ie_ack, if_rdata}), 32'({2'b10, 8'hA2}));
        if_req = 1'b0;
        tick();

        // Idle stability
        repeat (20) begin
            tick();
            check("idle", 32'({mem_en, if_ack, ie_ack, if_rdata, ie_rdata}), 32'(0));
        end

        // Random traffic against the reference memory
        if_pend = 0; ie_pend = 0; prev_ack = 0;
        if_wait = 0; ie_wait = 0; if_a = '0; ie_a = '0; ie_d = '0; ie_w = 0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            tick();
            any_ack = if_ack | ie_ack;
            check("rnd_invariants", 32'({if_ack & ie_ack, prev_ack & any_ack,
                                         !if_ack && (if_rdata != '0), !ie_ack && (ie_rdata != '0),
                                         mem_we & !mem_en}), 32'(0));
            prev_ack = any_ack;
            if (if_pend) if_wait++;
            if (ie_pend) ie_wait++;

            if (if_ack) begin
                check("rnd_if_pending", 32'(if_pend), 32'(1));
                check("rnd_if_data", 32'(if_rdata), 32'(ref_mem[if_a]));
                check("rnd_if_latency", 32'(if_wait >= 2 && if_wait <= IF_MAX_LAT), 32'(1));
                if_req = 1'b0; if_pend = 0;
            end else if (if_pend && if_wait > IF_MAX_LAT) begin
                check("rnd_if_timeout", 32'(if_wait), 32'(IF_MAX_LAT));
                if_req = 1'b0; if_pend = 0;
            end else if (!if_pend && cyc < 600 && $urandom_range(1) == 1) begin
                if_pend = 1; if_wait = 0;
                if_a = 16'($urandom_range(31));
                if_req = 1'b1; if_addr = if_a;
            end

            if (ie_ack) begin
                check("rnd_ie_pending", 32'(ie_pend), 32'(1));
                if (ie_w) ref_mem[ie_a] = ie_d;
                else check("rnd_ie_data", 32'(ie_rdata), 32'(ref_mem[ie_a]));
                check("rnd_ie_latency", 32'(ie_wait >= 2 && ie_wait <= IE_MAX_LAT), 32'(1));
                ie_req = 1'b0; ie_pend = 0;
            end else if (ie_pend && ie_wait > IE_MAX_LAT) begin
                check("rnd_ie_timeout", 32'(ie_wait), 32'(IE_MAX_LAT));
                ie_req = 1'b0; ie_pend = 0;
            end else if (!ie_pend && cyc < 600 && $urandom_range(1) == 1) begin
                ie_pend = 1; ie_wait = 0;
                ie_a = 16'($urandom_range(31));
                ie_w = ($urandom_range(1) == 1);
                ie_d = 8'($urandom_range(255));
                ie_req = 1'b1; ie_we = ie_w; ie_addr = ie_a; ie_wdata = ie_d;
            end
        end
        check("rnd_drain", 32'({if_pend, ie_pend}), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
